// File: rtl/judge_ctrl.sv
// Two-track rhythm-game judge: detects button presses, grades them against the
// note windows, and keeps score, combo and max combo for one game.
module judge_ctrl #(
    parameter int unsigned PERFECT_PTS = 3,
    parameter int unsigned NORMAL_PTS  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_song_end,
    input  logic        i_btn_t1,
    input  logic        i_btn_t2,
    input  logic        i_hit_t1,
    input  logic        i_hit_t2,
    input  logic        i_pre_hit_t1,
    input  logic        i_pre_hit_t2,
    input  logic        i_miss_t1,
    input  logic        i_miss_t2,
    output logic        o_clear_t1_perf,
    output logic        o_clear_t1_norm,
    output logic        o_clear_t2_perf,
    output logic        o_clear_t2_norm,
    output logic        o_play,
    output logic [1:0]  o_state,
    output logic [1:0]  o_judge,
    output logic        o_judge_valid,
    output logic [15:0] o_score,
    output logic [7:0]  o_combo,
    output logic [7:0]  o_max_combo
);

    localparam int unsigned SCORE_W = 16;
    localparam int unsigned COMBO_W = 8;
    localparam int unsigned SUM_W   = SCORE_W + 2;

    localparam logic [1:0] JUDGE_NONE    = 2'b00;
    localparam logic [1:0] JUDGE_PERFECT = 2'b01;
    localparam logic [1:0] JUDGE_NORMAL  = 2'b10;
    localparam logic [1:0] JUDGE_MISS    = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   btn_t1_q, btn_t2_q;

    logic                 in_play, enter_play;
    logic                 press_t1, press_t2;
    logic                 perf_t1, perf_t2, norm_t1, norm_t2;
    logic                 miss_any, norm_any, perf_any, judge_any;
    logic [SUM_W-1:0]     pts, score_sum;
    logic [COMBO_W:0]     combo_sum;
    logic [1:0]           hit_cnt;
    logic [SCORE_W-1:0]   score_d;
    logic [COMBO_W-1:0]   combo_d, max_combo_d;
    logic [1:0]           judge_d;

    // Next-state logic: start only from IDLE/DONE, song end only from PLAY
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start)    state_d = PLAY;
            PLAY:    if (i_song_end) state_d = DONE;
            DONE:    if (i_start)    state_d = PLAY;
            default: state_d = IDLE;
        endcase
    end

    // Judgement and counter update; a miss on a track masks that track's press
    always_comb begin
        in_play    = (state_q == PLAY);
        enter_play = (state_d == PLAY) && (state_q != PLAY);
        press_t1   = i_btn_t1 & ~btn_t1_q;
        press_t2   = i_btn_t2 & ~btn_t2_q;

        perf_t1 = in_play & press_t1 & ~i_miss_t1 & i_hit_t1;
        norm_t1 = in_play & press_t1 & ~i_miss_t1 & ~i_hit_t1 & i_pre_hit_t1;
        perf_t2 = in_play & press_t2 & ~i_miss_t2 & i_hit_t2;
        norm_t2 = in_play & press_t2 & ~i_miss_t2 & ~i_hit_t2 & i_pre_hit_t2;

        miss_any  = in_play & (i_miss_t1 | i_miss_t2);
        norm_any  = norm_t1 | norm_t2;
        perf_any  = perf_t1 | perf_t2;
        judge_any = miss_any | norm_any | perf_any;

        pts = SUM_W'(0);
        if (perf_t1) pts = pts + SUM_W'(PERFECT_PTS);
        if (perf_t2) pts = pts + SUM_W'(PERFECT_PTS);
        if (norm_t1) pts = pts + SUM_W'(NORMAL_PTS);
        if (norm_t2) pts = pts + SUM_W'(NORMAL_PTS);
        score_sum = SUM_W'(o_score) + pts;
        score_d   = (score_sum > SUM_W'(16'hFFFF)) ? 16'hFFFF : score_sum[SCORE_W-1:0];

        hit_cnt   = 2'(perf_t1 | norm_t1) + 2'(perf_t2 | norm_t2);
        combo_sum = (COMBO_W+1)'(o_combo) + (COMBO_W+1)'(hit_cnt);
        if (miss_any)
            combo_d = '0;
        else if (combo_sum > (COMBO_W+1)'(255))
            combo_d = 8'hFF;
        else
            combo_d = combo_sum[COMBO_W-1:0];
        max_combo_d = (combo_d > o_max_combo) ? combo_d : o_max_combo;

        judge_d = o_judge;
        if (miss_any)      judge_d = JUDGE_MISS;
        else if (norm_any) judge_d = JUDGE_NORMAL;
        else if (perf_any) judge_d = JUDGE_PERFECT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            btn_t1_q        <= 1'b0;
            btn_t2_q        <= 1'b0;
            o_state         <= IDLE;
            o_play          <= 1'b0;
            o_clear_t1_perf <= 1'b0;
            o_clear_t1_norm <= 1'b0;
            o_clear_t2_perf <= 1'b0;
            o_clear_t2_norm <= 1'b0;
            o_judge         <= JUDGE_NONE;
            o_judge_valid   <= 1'b0;
            o_score         <= '0;
            o_combo         <= '0;
            o_max_combo     <= '0;
        end else begin
            state_q         <= state_d;
            btn_t1_q        <= i_btn_t1;
            btn_t2_q        <= i_btn_t2;
            o_state         <= state_d;
            o_play          <= (state_d == PLAY);
            o_clear_t1_perf <= perf_t1;
            o_clear_t1_norm <= norm_t1;
            o_clear_t2_perf <= perf_t2;
            o_clear_t2_norm <= norm_t2;
            o_judge_valid   <= judge_any;
            if (enter_play) begin
                o_judge     <= JUDGE_NONE;
                o_score     <= '0;
                o_combo     <= '0;
                o_max_combo <= '0;
            end else if (judge_any) begin
                o_judge     <= judge_d;
                o_score     <= score_d;
                o_combo     <= combo_d;
                o_max_combo <= max_combo_d;
            end
        end
    end

endmodule

// File: tb/tb_judge_ctrl.sv
// Directed bench for judge_ctrl: hand-computed expectations checked with
// immediate assertions after each step.
module tb_judge_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start, i_song_end;
    logic        i_btn_t1, i_btn_t2, i_hit_t1, i_hit_t2;
    logic        i_pre_hit_t1, i_pre_hit_t2, i_miss_t1, i_miss_t2;
    logic        o_clear_t1_perf, o_clear_t1_norm, o_clear_t2_perf, o_clear_t2_norm;
    logic        o_play, o_judge_valid;
    logic [1:0]  o_state, o_judge;
    logic [15:0] o_score;
    logic [7:0]  o_combo, o_max_combo;

    int n_checks = 0;
    int n_fail   = 0;
    int vcount;

    judge_ctrl #(.PERFECT_PTS(3), .NORMAL_PTS(1)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_song_end(i_song_end),
        .i_btn_t1(i_btn_t1), .i_btn_t2(i_btn_t2),
        .i_hit_t1(i_hit_t1), .i_hit_t2(i_hit_t2),
        .i_pre_hit_t1(i_pre_hit_t1), .i_pre_hit_t2(i_pre_hit_t2),
        .i_miss_t1(i_miss_t1), .i_miss_t2(i_miss_t2),
        .o_clear_t1_perf(o_clear_t1_perf), .o_clear_t1_norm(o_clear_t1_norm),
        .o_clear_t2_perf(o_clear_t2_perf), .o_clear_t2_norm(o_clear_t2_norm),
        .o_play(o_play), .o_state(o_state), .o_judge(o_judge),
        .o_judge_valid(o_judge_valid), .o_score(o_score),
        .o_combo(o_combo), .o_max_combo(o_max_combo)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        i_start = 0; i_song_end = 0; i_btn_t1 = 0; i_btn_t2 = 0;
        i_hit_t1 = 0; i_hit_t2 = 0; i_pre_hit_t1 = 0; i_pre_hit_t2 = 0;
        i_miss_t1 = 0; i_miss_t2 = 0;
    endtask

    // Perfect on t1 followed by a release cycle
    task automatic perfect_t1();
        i_btn_t1 = 1; i_hit_t1 = 1;
        tick();
        i_btn_t1 = 0; i_hit_t1 = 0;
        tick();
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        #5;
        chk("rst_state", 32'(o_state), 0);
        chk("rst_play", 32'(o_play), 0);
        chk("rst_judge", 32'(o_judge), 0);
        chk("rst_valid", 32'(o_judge_valid), 0);
        chk("rst_score", 32'(o_score), 0);
        chk("rst_combo", 32'(o_combo), 0);
        chk("rst_max", 32'(o_max_combo), 0);

        @(negedge clk);
        rst_n = 1;
        tick();
        // Press in IDLE must not judge
        i_btn_t1 = 1; i_hit_t1 = 1;
        tick();
        chk("idle_press_valid", 32'(o_judge_valid), 0);
        chk("idle_press_clear", 32'(o_clear_t1_perf), 0);
        chk("idle_state", 32'(o_state), 0);
        i_btn_t1 = 0; i_hit_t1 = 0;

        i_start = 1;
        tick();
        i_start = 0;
        chk("start_state", 32'(o_state), 1);
        chk("start_play", 32'(o_play), 1);

        // Perfect on t1
        i_btn_t1 = 1; i_hit_t1 = 1;
        tick();
        chk("p1_clear", 32'(o_clear_t1_perf), 1);
        chk("p1_norm_clear", 32'(o_clear_t1_norm), 0);
        chk("p1_judge", 32'(o_judge), 1);
        chk("p1_valid", 32'(o_judge_valid), 1);
        chk("p1_score", 32'(o_score), 3);
        chk("p1_combo", 32'(o_combo), 1);
        i_btn_t1 = 0; i_hit_t1 = 0;
        tick();
        chk("p1_clear_pulse", 32'(o_clear_t1_perf), 0);
        chk("p1_valid_pulse", 32'(o_judge_valid), 0);

        // Normal on t2, then hold for 100 cycles
        i_btn_t2 = 1; i_pre_hit_t2 = 1;
        tick();
        chk("n2_clear", 32'(o_clear_t2_norm), 1);
        chk("n2_perf_clear", 32'(o_clear_t2_perf), 0);
        chk("n2_judge", 32'(o_judge), 2);
        chk("n2_score", 32'(o_score), 4);
        chk("n2_combo", 32'(o_combo), 2);
        vcount = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (o_judge_valid || o_clear_t2_norm) vcount++;
        end
        chk("hold_no_event", 32'(vcount), 0);
        chk("hold_score", 32'(o_score), 4);
        i_btn_t2 = 0; i_pre_hit_t2 = 0;
        tick();

        // Combo to 5, then Perfect t1 with miss t2
        perfect_t1(); perfect_t1(); perfect_t1();
        chk("c5_combo", 32'(o_combo), 5);
        chk("c5_score", 32'(o_score), 13);
        i_btn_t1 = 1; i_hit_t1 = 1; i_miss_t2 = 1;
        tick();
        chk("pm_score", 32'(o_score), 16);
        chk("pm_combo", 32'(o_combo), 0);
        chk("pm_max", 32'(o_max_combo), 5);
        chk("pm_judge", 32'(o_judge), 3);
        chk("pm_valid", 32'(o_judge_valid), 1);
        chk("pm_clear", 32'(o_clear_t1_perf), 1);
        i_btn_t1 = 0; i_hit_t1 = 0; i_miss_t2 = 0;
        tick();
        chk("pm_single_pulse", 32'(o_judge_valid), 0);

        // Miss and press on the same track
        i_btn_t1 = 1; i_hit_t1 = 1; i_miss_t1 = 1;
        tick();
        chk("mp_clear", 32'(o_clear_t1_perf), 0);
        chk("mp_judge", 32'(o_judge), 3);
        chk("mp_score", 32'(o_score), 16);
        chk("mp_valid", 32'(o_judge_valid), 1);
        i_btn_t1 = 0; i_hit_t1 = 0; i_miss_t1 = 0;
        tick();

        // Press with no note: nothing happens
        i_btn_t1 = 1;
        tick();
        chk("empty_valid", 32'(o_judge_valid), 0);
        chk("empty_score", 32'(o_score), 16);
        i_btn_t1 = 0;
        tick();

        // Song end coinciding with a Perfect
        i_btn_t1 = 1; i_hit_t1 = 1; i_song_end = 1;
        tick();
        i_song_end = 0;
        chk("end_state", 32'(o_state), 2);
        chk("end_play", 32'(o_play), 0);
        chk("end_score", 32'(o_score), 19);
        chk("end_combo", 32'(o_combo), 1);
        chk("end_max", 32'(o_max_combo), 5);
        chk("end_clear", 32'(o_clear_t1_perf), 1);
        i_btn_t1 = 0; i_hit_t1 = 0;
        tick();
        i_btn_t1 = 1; i_hit_t1 = 1; i_miss_t2 = 1;
        tick();
        chk("done_clear", 32'(o_clear_t1_perf), 0);
        chk("done_valid", 32'(o_judge_valid), 0);
        chk("done_score", 32'(o_score), 19);
        chk("done_combo", 32'(o_combo), 1);
        i_btn_t1 = 0; i_hit_t1 = 0; i_miss_t2 = 0;
        tick();

        // Restart clears counters
        i_start = 1;
        tick();
        i_start = 0;
        chk("restart_state", 32'(o_state), 1);
        chk("restart_score", 32'(o_score), 0);
        chk("restart_combo", 32'(o_combo), 0);
        chk("restart_max", 32'(o_max_combo), 0);

        // Double Perfects: 10922 pairs -> 65532 points, combo saturates
        i_hit_t1 = 1; i_hit_t2 = 1;
        for (int i = 0; i < 10922; i++) begin
            i_btn_t1 = 1; i_btn_t2 = 1;
            tick();
            i_btn_t1 = 0; i_btn_t2 = 0;
            tick();
        end
        chk("sat_score_pre", 32'(o_score), 65532);
        chk("sat_combo", 32'(o_combo), 255);
        chk("sat_max", 32'(o_max_combo), 255);
        i_hit_t1 = 0; i_hit_t2 = 0; i_pre_hit_t1 = 1; i_pre_hit_t2 = 1;
        i_btn_t1 = 1;
        tick();
        i_btn_t1 = 0;
        tick();
        i_btn_t2 = 1;
        tick();
        i_btn_t2 = 0;
        chk("sat_fffe", 32'(o_score), 65534);
        chk("sat_combo_hold", 32'(o_combo), 255);
        tick();
        i_pre_hit_t1 = 0; i_pre_hit_t2 = 0; i_hit_t1 = 1; i_hit_t2 = 1;
        i_btn_t1 = 1; i_btn_t2 = 1;
        tick();
        chk("sat_ffff", 32'(o_score), 65535);
        chk("sat_double_judge", 32'(o_judge), 1);
        i_btn_t1 = 0; i_btn_t2 = 0;
        tick();
        i_btn_t1 = 1; i_btn_t2 = 1;
        tick();
        chk("sat_ffff_hold", 32'(o_score), 65535);
        chk("sat_double_clear", 32'(o_clear_t2_perf), 1);

        // Reset mid-PLAY aborts at once, even mid-pulse
        rst_n = 0;
        #1;
        chk("arst_state", 32'(o_state), 0);
        chk("arst_play", 32'(o_play), 0);
        chk("arst_valid", 32'(o_judge_valid), 0);
        chk("arst_clear", 32'(o_clear_t1_perf), 0);
        chk("arst_score", 32'(o_score), 0);
        chk("arst_combo", 32'(o_combo), 0);
        chk("arst_max", 32'(o_max_combo), 0);
        chk("arst_judge", 32'(o_judge), 0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
        tick(); tick();
        chk("post_rst_idle", 32'(o_state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/judge_ctrl.md
JUDGE_CTRL -- requirements
Module: judge_ctrl

Interface
REQ-001 SHALL have parameters: PERFECT_PTS, 3, points per Perfect; NORMAL_PTS, 1, points per Normal.
REQ-002 SHALL have ports, one clock, asynchronous active-low reset:
 clk  in  1  system clock, 50 MHz
 rst_n  in  1  asynchronous active-low reset
 i_start  in  1  start/restart pulse, one cycle
 i_song_end  in  1  end-of-chart pulse, one cycle
 i_btn_t1, i_btn_t2  in  1 each  debounced button levels, high = pressed
 i_hit_t1, i_hit_t2  in  1 each  note in column 0 (Perfect window)
 i_pre_hit_t1, i_pre_hit_t2  in  1 each  note in column 1 (Normal window)
 i_miss_t1, i_miss_t2  in  1 each  note scrolled off, one-cycle pulse
 o_clear_t1_perf, o_clear_t1_norm, o_clear_t2_perf, o_clear_t2_norm  out  1 each  one-cycle note-erase pulses to the LCD controller
 o_play  out  1  high in PLAY; enables the note generator
 o_state  out  2  00 IDLE, 01 PLAY, 10 DONE
 o_judge  out  2  00 none, 01 Perfect, 10 Normal, 11 Miss
 o_judge_valid  out  1  one-cycle pulse, o_judge is valid
 o_score  out  16  accumulated score
 o_combo  out  8  current combo
 o_max_combo  out  8  highest combo this game

Function
REQ-003 SHALL implement the FSM: IDLE -i_start-> PLAY; PLAY -i_song_end-> DONE; DONE -i_start-> PLAY; no other transitions; i_start in PLAY is ignored.
REQ-004 SHALL clear o_score, o_combo and o_max_combo to 0 on every transition into PLAY.
REQ-005 SHALL drive o_play = 1 exactly when state = PLAY; o_state SHALL be registered.
REQ-006 SHALL register each i_btn_tX every cycle in every state; press event = btn high and previous sample low, so one press yields one event however long it is held.
REQ-007 SHALL evaluate press events only in PLAY, from the i_hit/i_pre_hit values of the same cycle as the event.
REQ-008 Per track press: hit=1 -> Perfect, o_clear_tX_perf; else pre_hit=1 -> Normal, o_clear_tX_norm; else no judgement, no clear, no penalty.
REQ-009 All judgement outputs (clears, o_judge, o_judge_valid, score, combo) SHALL be registered, one cycle after the event cycle; clear pulses last exactly one cycle.
REQ-010 i_miss_tX in PLAY SHALL judge Miss and set combo to 0; a press on the same track in the same cycle SHALL be ignored (no clear, no points).
REQ-011 Score: add PERFECT_PTS per Perfect and NORMAL_PTS per Normal; both tracks in one cycle add both amounts; saturate at 16'hFFFF, never wrap.
REQ-012 Combo: +1 per Perfect/Normal (+2 if both tracks hit in one cycle), saturate at 255; any Miss in a cycle forces combo to 0 for that cycle, while that cycle's hits still score.
REQ-013 o_max_combo SHALL update in the same cycle as o_combo, to max(o_max_combo, new combo).
REQ-014 Concurrent judgements: one o_judge_valid pulse; o_judge reports the worst result, priority Miss > Normal > Perfect.
REQ-015 Outside PLAY: clears, o_judge_valid and score/combo changes SHALL be 0; misses and presses are ignored; counters hold in DONE.
REQ-016 i_song_end coinciding with a press or miss SHALL still judge that event; state reaches DONE in the same update.

Reset
REQ-017 On rst_n low, asynchronously: state IDLE, all outputs 0 (o_judge = 00), button history registers 0.
REQ-018 Reset asserted mid-PLAY SHALL abort the game immediately; after release the block waits in IDLE for i_start.

Verification
REQ-019 Reset, i_start, btn_t1 rises with i_hit_t1=1 -> next cycle o_clear_t1_perf pulse, o_judge=01, score 3, combo 1.
REQ-020 btn_t2 rises with i_hit_t2=0, i_pre_hit_t2=1 -> o_clear_t2_norm pulse, o_judge=10, score +1; btn held 100 cycles -> no second event.
REQ-021 Combo 5, Perfect on t1 and i_miss_t2 in the same cycle -> score +3, combo 0, max_combo 5, o_judge=11, single valid pulse.
REQ-022 Score preset near 16'hFFFE plus two simultaneous Perfects -> score 16'hFFFF; 300 consecutive hits -> combo holds 255.
REQ-023 i_miss_t1 and btn_t1 rise with i_hit_t1=1 in the same cycle -> no clear pulse, o_judge=11, score unchanged.
REQ-024 i_song_end -> DONE, o_play 0, later presses produce no clears; i_start -> PLAY, counters 0; rst_n low mid-PLAY -> all outputs 0 at once.
